// File: rtl/io_in_pad_filt.sv
// io_in_pad_filt
//   Chip-boundary input pad for a WIDTH-bit bundle of asynchronous pins.
//   Each bit passes through a SYNC_STAGES-deep synchroniser and a glitch
//   filter. The filtered value is fanned out FANOUT times, and one-cycle
//   rise/fall pulses mark each filtered transition.
//
// Ports
//   clk      in   1             rising-edge clock
//   rst      in   1             asynchronous active-low reset
//   top_pin  in   WIDTH         raw asynchronous pad inputs
//   pin_out  out  FANOUT*WIDTH  filtered copies, copy k of bit i at k*WIDTH+i
//   rise     out  WIDTH         one-cycle pulse on filtered 0->1
//   fall     out  WIDTH         one-cycle pulse on filtered 1->0
module io_in_pad_filt #(
    parameter int unsigned WIDTH         = 1,
    parameter int unsigned FANOUT        = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4,
    parameter logic        RESET_VAL     = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          top_pin,
    output logic [FANOUT*WIDTH-1:0]   pin_out,
    output logic [WIDTH-1:0]          rise,
    output logic [WIDTH-1:0]          fall
);

    localparam int unsigned          CNT_W    = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_last;

    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Plain shift chain, no logic between stages.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= {WIDTH{RESET_VAL}};
            end
        end else begin
            sync_q[0] <= top_pin;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];

    // A differing run must reach FILTER_CYCLES samples to commit; any
    // matching sample throws the partial run away.
    always_comb begin
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_last[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync_last[i];
                cnt_d[i]    = '0;
                rise_d[i]   = sync_last[i];
                fall_d[i]   = ~sync_last[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_q <= {WIDTH{RESET_VAL}};
            rise_q   <= '0;
            fall_q   <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Pure wire fanout; edge pulses line up with the new pin_out value.
    assign pin_out = {FANOUT{stable_q}};
    assign rise    = rise_q;
    assign fall    = fall_q;

endmodule

// File: tb/tb_io_in_pad_filt.sv
// tb_io_in_pad_filt
//   Two instances: A uses the default timing (S=2, F=4, reset value 0),
//   B uses S=3, F=1, reset value 1. Both are compared every cycle against
//   a window model: the filtered bit flips when the last F synchroniser
//   outputs, taken from a sample history, all differ from it.
module tb_io_in_pad_filt;

    localparam int   W  = 2;
    localparam int   FA = 4;
    localparam int   SA = 2;
    localparam int   CA = 4;
    localparam logic RA = 1'b0;
    localparam int   FB = 2;
    localparam int   SB = 3;
    localparam int   CB = 1;
    localparam logic RB = 1'b1;

    logic            clk;
    logic            rst;
    logic [W-1:0]    tp_a, tp_b;
    logic [FA*W-1:0] po_a;
    logic [FB*W-1:0] po_b;
    logic [W-1:0]    rise_a, fall_a, rise_b, fall_b;

    int total = 0;
    int bad   = 0;

    io_in_pad_filt #(
        .WIDTH(W), .FANOUT(FA), .SYNC_STAGES(SA), .FILTER_CYCLES(CA), .RESET_VAL(RA)
    ) u_dut_a (
        .clk(clk), .rst(rst), .top_pin(tp_a),
        .pin_out(po_a), .rise(rise_a), .fall(fall_a)
    );

    io_in_pad_filt #(
        .WIDTH(W), .FANOUT(FB), .SYNC_STAGES(SB), .FILTER_CYCLES(CB), .RESET_VAL(RB)
    ) u_dut_b (
        .clk(clk), .rst(rst), .top_pin(tp_b),
        .pin_out(po_b), .rise(rise_b), .fall(fall_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic [W-1:0] stab_a, rise_ma, fall_ma;
    logic [W-1:0] stab_b, rise_mb, fall_mb;

    // Bits whose last f filter inputs all differ from the current stable
    // value. h[h.size()-k] is the sample taken k edges ago, so the filter
    // input at this edge is the sample taken s edges ago.
    function automatic logic [W-1:0] commit_mask(input logic [W-1:0] h[$], input int s,
                                                 input int f, input logic [W-1:0] st);
        logic [W-1:0] m;
        m = '1;
        for (int b = 0; b < W; b++) begin
            for (int j = 0; j < f; j++) begin
                if (h[h.size() - s - j][b] == st[b]) m[b] = 1'b0;
            end
        end
        return m;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            qa.delete();
            qb.delete();
            for (int i = 0; i < SA + CA; i++) qa.push_back({W{RA}});
            for (int i = 0; i < SB + CB; i++) qb.push_back({W{RB}});
            stab_a  <= {W{RA}};
            rise_ma <= '0;
            fall_ma <= '0;
            stab_b  <= {W{RB}};
            rise_mb <= '0;
            fall_mb <= '0;
        end else begin
            stab_a  <= stab_a ^ commit_mask(qa, SA, CA, stab_a);
            rise_ma <= commit_mask(qa, SA, CA, stab_a) & ~stab_a;
            fall_ma <= commit_mask(qa, SA, CA, stab_a) & stab_a;
            stab_b  <= stab_b ^ commit_mask(qb, SB, CB, stab_b);
            rise_mb <= commit_mask(qb, SB, CB, stab_b) & ~stab_b;
            fall_mb <= commit_mask(qb, SB, CB, stab_b) & stab_b;
            qa.push_back(tp_a);
            qb.push_back(tp_b);
            void'(qa.pop_front());
            void'(qb.pop_front());
        end
    end

    always @(negedge clk) begin
        check_eq("A.pin_out", 32'(po_a),   32'({FA{stab_a}}));
        check_eq("A.rise",    32'(rise_a), 32'(rise_ma));
        check_eq("A.fall",    32'(fall_a), 32'(fall_ma));
        check_eq("B.pin_out", 32'(po_b),   32'({FB{stab_b}}));
        check_eq("B.rise",    32'(rise_b), 32'(rise_mb));
        check_eq("B.fall",    32'(fall_b), 32'(fall_mb));
    end

    // ---------------- directed helpers ----------------
    // k counts negedges after the first sampling edge; the change must land
    // exactly at k=5 for S=2, F=4.
    task automatic lat_loop_a(input logic [W-1:0] from, input logic [W-1:0] to);
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            check_eq("A.lat.pin_out", 32'(po_a), (k >= 5) ? 32'({FA{to}}) : 32'({FA{from}}));
            check_eq("A.lat.rise", 32'(rise_a), (k == 5) ? 32'(to & ~from) : 32'd0);
            check_eq("A.lat.fall", 32'(fall_a), (k == 5) ? 32'(from & ~to) : 32'd0);
        end
    endtask

    task automatic lat_a(input logic [W-1:0] from, input logic [W-1:0] to);
        @(negedge clk);
        tp_a = to;
        lat_loop_a(from, to);
    endtask

    task automatic mid_reset();
        #2 rst = 1'b0;
        #1;
        check_eq("rst.A.pin_out", 32'(po_a), 32'd0);
        check_eq("rst.A.rise",    32'(rise_a), 32'd0);
        check_eq("rst.A.fall",    32'(fall_a), 32'd0);
        check_eq("rst.B.pin_out", 32'(po_b), 32'hF);
        check_eq("rst.B.rise",    32'(rise_b), 32'd0);
        check_eq("rst.B.fall",    32'(fall_b), 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int glitch[14] = '{1, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        int pulses;
        int ha, hb;

        rst  = 1'b1;
        tp_a = 2'b00;
        tp_b = 2'b11;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // B held at its reset value through release: no pulses, all ones.
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_eq("B.hold.pin_out", 32'(po_b), 32'hF);
            check_eq("B.hold.edges", 32'({rise_b, fall_b}), 32'd0);
        end

        lat_a(2'b00, 2'b01);
        repeat (3) @(negedge clk);
        lat_a(2'b01, 2'b11);
        repeat (3) @(negedge clk);
        lat_a(2'b11, 2'b00);

        // Short high runs separated by a one-sample gap never qualify.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            tp_a = 2'(glitch[i]);
            check_eq("A.glitch.pin_out", 32'(po_a), 32'd0);
            check_eq("A.glitch.rise", 32'(rise_a), 32'd0);
        end

        // Reset with a count pending at 3, then full latency again.
        repeat (4) @(negedge clk);
        @(negedge clk);
        tp_a = 2'b01;
        repeat (5) @(negedge clk);
        mid_reset();
        lat_loop_a(2'b00, 2'b01);

        // B bit 1 toggling every 2 cycles: every transition gives a pulse.
        pulses = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (c < 16 && (c % 2) == 0) tp_b[1] = ~tp_b[1];
            pulses += int'(rise_b[1]) + int'(fall_b[1]);
        end
        check_eq("B.toggle.pulses", 32'(pulses), 32'd8);

        // Randomized run lengths with occasional mid-cycle resets.
        ha = 0;
        hb = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (ha == 0) begin
                tp_a = 2'($urandom);
                ha   = $urandom_range(1, 7);
            end
            if (hb == 0) begin
                tp_b = 2'($urandom);
                hb   = $urandom_range(1, 5);
            end
            ha--;
            hb--;
            if ($urandom_range(0, 79) == 0) mid_reset();
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
